ct_unpack_loader: RTL

- Receive side of the ciphertext word stream produced by the ROLLO-II encrypt top, which emits 32-bit words masked with the SHA3 digest.
- Accepts 32-bit masked words over a valid/ready handshake and unmasks each with the latched 512-bit digest.
- Packs the unmasked words into m*digit-wide rows and writes them sequentially into the single-port ciphertext memory used by the decrypt datapath.
- Signals completion to the decrypt controller.

---
 rtl/ct_unpack_loader_pkg.sv | 38 +++
 rtl/ct_unpack_loader_if.sv | 22 ++
 rtl/ct_unpack_loader_word_unmask_pack.sv | 72 +++++++
 rtl/ct_unpack_loader.sv | 109 ++++++++++
 4 files changed

// File: rtl/ct_unpack_loader_pkg.sv
// Shared ROLLO-II constants, derived ciphertext-memory geometry and loader state encoding.
package ct_unpack_loader_pkg;

    localparam int N     = 189;
    localparam int M     = 83;
    localparam int R     = 7;
    localparam int D     = 8;
    localparam int DIGIT = 1;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Never returns less than 1 so a single-row or single-beat geometry still yields a legal vector width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

    localparam int WORD_W = M * DIGIT;
    localparam int DEPTH  = ceil_div(N, DIGIT);
    localparam int BEATS  = ceil_div(WORD_W, 32);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        WRITE = ST_WRITE,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/ct_unpack_loader_if.sv
// Masked word stream in, ciphertext memory write port out.
interface ct_unpack_loader_if #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 83
);
    logic [31:0]       in_data;
    logic              in_valid;
    logic              in_ready;
    logic              ct_we;
    logic [ADDR_W-1:0] ct_addr;
    logic [WORD_W-1:0] ct_dout;

    modport master (
        output in_data, in_valid,
        input  in_ready, ct_we, ct_addr, ct_dout
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, ct_we, ct_addr, ct_dout
    );
endinterface

// File: rtl/ct_unpack_loader_word_unmask_pack.sv
// Unmasks accepted beats with the latched digest and assembles them into one memory row.
module ct_unpack_loader_word_unmask_pack
    import ct_unpack_loader_pkg::*;
#(
    parameter int ROW_W  = 83,
    parameter int NBEATS = 3
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              clear,
    input  logic [511:0]      mask,
    input  logic              beat_en,
    input  logic [31:0]       data,
    output logic [ROW_W-1:0]  row_next,
    output logic              last_beat,
    output logic              pad_err
);

    localparam int BUF_W  = 32 * NBEATS;
    localparam int BEAT_W = clog2(NBEATS);

    logic [511:0]       mask_reg;
    logic [3:0]         mask_idx;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [BUF_W-1:0]   row_buf;
    logic [BUF_W-1:0]   buf_next;
    logic [31:0]        word;
    logic               pad_hit;

    assign word      = data ^ mask_reg[32*mask_idx +: 32];
    assign last_beat = (beat_cnt == BEAT_W'(NBEATS - 1));

    always_comb begin
        buf_next = row_buf;
        buf_next[32*beat_cnt +: 32] = word;
        row_next = buf_next[ROW_W-1:0];
    end

    // The buffer's last-beat slot is always empty, so bits above ROW_W come straight from the incoming word.
    if (BUF_W > ROW_W) begin : g_pad
        assign pad_hit = beat_en & last_beat & (|buf_next[BUF_W-1:ROW_W]);
    end else begin : g_nopad
        assign pad_hit = 1'b0;
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            mask_reg <= '0;
            mask_idx <= '0;
            beat_cnt <= '0;
            row_buf  <= '0;
            pad_err  <= 1'b0;
        end else if (clear) begin
            mask_reg <= mask;
            mask_idx <= '0;
            beat_cnt <= '0;
            row_buf  <= '0;
            pad_err  <= 1'b0;
        end else if (beat_en) begin
            mask_idx <= mask_idx + 4'd1;
            if (last_beat) begin
                beat_cnt <= '0;
                row_buf  <= '0;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
                row_buf  <= buf_next;
            end
            if (pad_hit) pad_err <= 1'b1;
        end
    end

endmodule

// File: rtl/ct_unpack_loader.sv
// Loads a masked ciphertext word stream into the decrypt-side ciphertext memory, one row per WRITE cycle.
module ct_unpack_loader
    import ct_unpack_loader_pkg::*;
#(
    parameter int CT_N     = N,
    parameter int CT_M     = M,
    parameter int CT_DIGIT = DIGIT
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          start,
    input  logic [511:0]  mask,
    output logic          busy,
    output logic          done,
    output logic          pad_err,
    ct_unpack_loader_if.slave bus
);

    localparam int ROW_W  = CT_M * CT_DIGIT;
    localparam int ROWS   = ceil_div(CT_N, CT_DIGIT);
    localparam int NBEATS = ceil_div(ROW_W, 32);
    localparam int ADDR_W = clog2(ROWS);

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  row;
    logic               accept;
    logic               start_ok;
    logic               last_beat;
    logic               last_row;
    logic [ROW_W-1:0]   row_next;

    assign bus.in_ready = (state == LOAD);
    assign accept       = bus.in_valid & bus.in_ready;
    assign start_ok     = start & (state == IDLE);
    assign last_row     = (row == ADDR_W'(ROWS - 1));

    ct_unpack_loader_word_unmask_pack #(
        .ROW_W  (ROW_W),
        .NBEATS (NBEATS)
    ) u_pack (
        .clk       (clk),
        .rst_b     (rst_b),
        .clear     (start_ok),
        .mask      (mask),
        .beat_en   (accept),
        .data      (bus.in_data),
        .row_next  (row_next),
        .last_beat (last_beat),
        .pad_err   (pad_err)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    if (accept && last_beat) state_next = WRITE;
            WRITE:   state_next = last_row ? DONE : LOAD;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory port is registered and returns to zero on the way back to IDLE because it feeds a shared OR-mux.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state       <= IDLE;
            row         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bus.ct_we   <= 1'b0;
            bus.ct_addr <= '0;
            bus.ct_dout <= '0;
        end else begin
            state     <= state_next;
            done      <= 1'b0;
            bus.ct_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        row  <= '0;
                    end
                end
                LOAD: begin
                    if (accept && last_beat) begin
                        bus.ct_we   <= 1'b1;
                        bus.ct_addr <= row;
                        bus.ct_dout <= row_next;
                    end
                end
                WRITE: begin
                    if (last_row) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        row <= row + 1'b1;
                    end
                end
                DONE: begin
                    bus.ct_addr <= '0;
                    bus.ct_dout <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
